cfg_frame_receiver: RTL and testbench
=====================================

Name: cfg_frame_receiver

Overview:
- Parametrised successor to the fixed 137-bit serial config shifter.
- Receives a framed serial configuration word (key, address, location, mode, parity) one bit per strobe, MSB first.
- Checks even parity, then atomically commits the fields to held output registers.
- Sits between the off-chip serial config interface and the AES core / memory-address logic. Supports abort and reports frame errors.

Parameters:
- KEY_W, 128, key field width in bits
- ADDR_W, 8, address field width
- LOC_W, 8, location field width
- DATA_W, KEY_W+ADDR_W+LOC_W+1, payload width; derived, not overridden
- CNT_W, $clog2(DATA_W+2), bit-counter width; derived

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  begin a frame; honoured only in IDLE
- abort  input  1  discard the frame in progress
- bit_valid  input  1  serial_in is valid this cycle
- serial_in  input  1  serial data, MSB first
- key  output  KEY_W  committed key
- address  output  ADDR_W  committed address
- location  output  LOC_W  committed location
- mode  output  1  committed mode (1 = encrypt, 0 = decrypt)
- cfg_valid  output  1  level: at least one good frame committed since reset
- done  output  1  one-cycle pulse on good commit
- frame_err  output  1  one-cycle pulse on parity failure
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset is async and active-low. All outputs, the shadow register and the counter go to 0, and state goes to IDLE. Reset mid-frame drops the frame with no pulse.
- Frame layout (DATA_W+1 bits, first bit received first): key[KEY_W-1:0], address, location, mode, parity bit.
- The frame is good when the XOR of all DATA_W+1 received bits is 0 (even parity).
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: start=1 and abort=0 -> SHIFT; counter cleared to 0.
  - SHIFT: each cycle with bit_valid=1, shadow <= {shadow, serial_in} and counter++. Payload bits fill a DATA_W shadow; the parity bit accumulates into a running XOR only. Cycles with bit_valid=0 hold all state.
  - SHIFT -> CHECK on the edge that samples bit number DATA_W+1 (the parity bit).
  - CHECK (exactly one cycle):
    - Good parity: key/address/location/mode load from shadow; cfg_valid <= 1; done=1 for one cycle.
    - Bad parity: frame_err=1 for one cycle; outputs and cfg_valid keep their previous values.
    - Either way -> IDLE.
- Latency: committed outputs and the done pulse appear after the first rising edge following the edge that sampled the parity bit.
- abort=1 in SHIFT -> IDLE next edge. Shadow contents are discarded, outputs do not change, and no pulse is raised.
- abort takes priority over bit_valid and start in the same cycle. abort in CHECK is ignored (the commit completes).
- start in SHIFT or CHECK is ignored and does not restart the frame.
- Committed outputs change only on a good commit. They never show partially shifted data.
- The counter never wraps. It saturates at DATA_W+1 and is cleared on entry to SHIFT.
- done and frame_err are never high together. busy is registered-state decoded.

Decomposition:
- Package cfg_rx_pkg holds:
  - state enum typedef (IDLE, SHIFT, CHECK);
  - localparam defaults KEY_W/ADDR_W/LOC_W;
  - a function computing DATA_W.
- Sub-module rx_bit_counter: parametrised up-counter with clear, enable and an at_target flag. It is instantiated once for the bit count.

Test Plan:
- Good frame: key=128'h000102030405060708090A0B0C0D0E0F, address=8'hA5, location=8'h3C, mode=1, correct parity bit, bit_valid every cycle -> done pulses once; outputs equal those values; cfg_valid=1; busy low the next cycle.
- Gapped frame: same frame with bit_valid low on every other cycle -> identical results; done arrives after 2x the cycles; no extra pulses.
- Parity error: second frame (key all 1s, address 8'h00) with the parity bit inverted -> frame_err pulses once; outputs still hold the first frame's values; cfg_valid stays 1.
- Abort after 50 bits, then a fresh good frame with address=8'h11 -> no pulse at abort; after the new frame, address=8'h11 and the key comes only from the new bits.
- start asserted mid-SHIFT, and start together with abort in IDLE -> frame unaffected / FSM stays IDLE, respectively.
- Reset pulse after 100 bits of a frame -> all outputs 0, cfg_valid=0, busy=0; a subsequent good frame commits normally.

Source files
------------

// File: rtl/cfg_rx_pkg.sv
// Shared types and sizing helpers for the serial configuration frame receiver.
package cfg_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    localparam int DEF_KEY_W  = 128;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LOC_W  = 8;

    // Payload is key + address + location + one mode bit; the parity bit is not stored.
    function automatic int calc_data_w(input int key_w, input int addr_w, input int loc_w);
        return key_w + addr_w + loc_w + 1;
    endfunction

endpackage

// File: rtl/cfg_frame_receiver_if.sv
// Serial-in / committed-config bundle between the off-chip config port and the receiver.
interface cfg_frame_receiver_if #(
    parameter int KEY_W  = cfg_rx_pkg::DEF_KEY_W,
    parameter int ADDR_W = cfg_rx_pkg::DEF_ADDR_W,
    parameter int LOC_W  = cfg_rx_pkg::DEF_LOC_W
);

    logic              start;
    logic              abort;
    logic              bit_valid;
    logic              serial_in;
    logic [KEY_W-1:0]  key;
    logic [ADDR_W-1:0] address;
    logic [LOC_W-1:0]  location;
    logic              mode;
    logic              cfg_valid;
    logic              done;
    logic              frame_err;
    logic              busy;

    modport master (
        output start, abort, bit_valid, serial_in,
        input  key, address, location, mode, cfg_valid, done, frame_err, busy
    );

    modport slave (
        input  start, abort, bit_valid, serial_in,
        output key, address, location, mode, cfg_valid, done, frame_err, busy
    );

endinterface

// File: rtl/rx_bit_counter.sv
// Saturating up-counter with synchronous clear; flags when the count equals TARGET.
module rx_bit_counter #(
    parameter int WIDTH  = 8,
    parameter int TARGET = 4,
    parameter int MAX    = 5
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr_i,
    input  logic en_i,
    output logic at_target_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != WIDTH'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_target_o = (cnt_q == WIDTH'(TARGET));

endmodule

// File: rtl/cfg_frame_receiver.sv
// Shifts in a parity-protected config frame MSB first and commits key/address/location/mode
// atomically only when the frame's even parity holds.
module cfg_frame_receiver
    import cfg_rx_pkg::*;
#(
    parameter int KEY_W  = DEF_KEY_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LOC_W  = DEF_LOC_W
) (
    input  logic                 clk,
    input  logic                 n_rst,
    cfg_frame_receiver_if.slave  bus
);

    localparam int DATA_W = calc_data_w(KEY_W, ADDR_W, LOC_W);
    localparam int CNT_W  = $clog2(DATA_W + 2);

    rx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shadow_q;
    logic              parity_q;
    logic [KEY_W-1:0]  key_q;
    logic [ADDR_W-1:0] address_q;
    logic [LOC_W-1:0]  location_q;
    logic              mode_q;
    logic              cfg_valid_q;
    logic              done_q;
    logic              frame_err_q;

    logic cnt_clr;
    logic cnt_en;
    logic payload_full;
    logic commit;
    logic reject;

    // payload_full means every payload bit is in; the next valid bit is the parity bit.
    rx_bit_counter #(
        .WIDTH  (CNT_W),
        .TARGET (DATA_W),
        .MAX    (DATA_W + 1)
    ) u_bit_cnt (
        .clk         (clk),
        .n_rst       (n_rst),
        .clr_i       (cnt_clr),
        .en_i        (cnt_en),
        .at_target_o (payload_full)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        commit  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = SHIFT;
                    cnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.bit_valid) begin
                    cnt_en = 1'b1;
                    if (payload_full) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (parity_q == 1'b0) begin
                    commit = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The parity bit only feeds the running XOR, so the shadow holds exactly the payload.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shadow_q    <= '0;
            parity_q    <= 1'b0;
            key_q       <= '0;
            address_q   <= '0;
            location_q  <= '0;
            mode_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            done_q      <= commit;
            frame_err_q <= reject;
            if (cnt_clr) begin
                parity_q <= 1'b0;
            end else if (cnt_en) begin
                parity_q <= parity_q ^ bus.serial_in;
            end
            if (cnt_en && !payload_full) begin
                shadow_q <= {shadow_q[DATA_W-2:0], bus.serial_in};
            end
            if (commit) begin
                key_q       <= shadow_q[DATA_W-1 -: KEY_W];
                address_q   <= shadow_q[DATA_W-1-KEY_W -: ADDR_W];
                location_q  <= shadow_q[LOC_W:1];
                mode_q      <= shadow_q[0];
                cfg_valid_q <= 1'b1;
            end
        end
    end

    assign bus.key       = key_q;
    assign bus.address   = address_q;
    assign bus.location  = location_q;
    assign bus.mode      = mode_q;
    assign bus.cfg_valid = cfg_valid_q;
    assign bus.done      = done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cfg_frame_receiver.sv
// Self-checking bench: directed frame table, multi-cycle corner sequences and randomized
// frames checked against a field-level model of the committed configuration.
module tb_cfg_frame_receiver;
    import cfg_rx_pkg::*;

    localparam int KEY_W  = 128;
    localparam int ADDR_W = 8;
    localparam int LOC_W  = 8;
    localparam int DATA_W = calc_data_w(KEY_W, ADDR_W, LOC_W);

    typedef struct {
        logic [KEY_W-1:0]  key;
        logic [ADDR_W-1:0] addr;
        logic [LOC_W-1:0]  loc;
        logic              mode;
        bit                flip;
        int                gapMode;
        logic [KEY_W-1:0]  expKey;
        logic [ADDR_W-1:0] expAddr;
        logic [LOC_W-1:0]  expLoc;
        logic              expMode;
        bit                expValid;
        bit                expDone;
        bit                expErr;
    } vec_t;

    logic clk;
    logic n_rst;

    int assertions = 0;
    int failures   = 0;
    int doneSeen   = 0;
    int errSeen    = 0;
    int bothHigh   = 0;

    logic [KEY_W-1:0]  cKey;
    logic [ADDR_W-1:0] cAddr;
    logic [LOC_W-1:0]  cLoc;
    logic              cMode;
    bit                cValid;

    vec_t vecs[3];

    cfg_frame_receiver_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .LOC_W(LOC_W)) bus ();

    cfg_frame_receiver #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .LOC_W(LOC_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) doneSeen++;
        if (bus.frame_err === 1'b1) errSeen++;
        if (bus.done === 1'b1 && bus.frame_err === 1'b1) bothHigh++;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W:0] buildFrame(input vec_t v);
        logic [DATA_W-1:0] payload;
        payload = {v.key, v.addr, v.loc, v.mode};
        return {payload, (^payload) ^ v.flip};
    endfunction

    // Drives start then nBits frame bits MSB first; stopAfter < 0 sends the whole frame.
    task automatic applyStimulus(input logic [DATA_W:0] frame, input int gapMode,
                                 input int midStartAt, input int stopAfter);
        int nBits;
        nBits = (stopAfter >= 0) ? stopAfter : DATA_W + 1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            if (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 1) == 1)) begin
                bus.bit_valid = 1'b0;
                bus.serial_in = 1'($urandom_range(0, 1));
                step();
            end
            bus.bit_valid = 1'b1;
            bus.serial_in = frame[DATA_W-i];
            bus.start     = (i == midStartAt);
            step();
        end
        bus.bit_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic frameCheck(input vec_t v, input string tag, input int midStartAt, input bit abortInCheck);
        int prevDone;
        int prevErr;
        prevDone = doneSeen;
        prevErr  = errSeen;
        applyStimulus(buildFrame(v), v.gapMode, midStartAt, -1);
        checkOutput({tag, " busy in check"}, 128'(bus.busy), 128'(1));
        checkOutput({tag, " done early"}, 128'(bus.done), 128'(0));
        checkOutput({tag, " key before commit"}, 128'(bus.key), 128'(cKey));
        bus.abort = abortInCheck;
        step();
        bus.abort = 1'b0;
        checkOutput({tag, " done"}, 128'(bus.done), 128'(v.expDone));
        checkOutput({tag, " frame_err"}, 128'(bus.frame_err), 128'(v.expErr));
        checkOutput({tag, " key"}, 128'(bus.key), 128'(v.expKey));
        checkOutput({tag, " address"}, 128'(bus.address), 128'(v.expAddr));
        checkOutput({tag, " location"}, 128'(bus.location), 128'(v.expLoc));
        checkOutput({tag, " mode"}, 128'(bus.mode), 128'(v.expMode));
        checkOutput({tag, " cfg_valid"}, 128'(bus.cfg_valid), 128'(v.expValid));
        checkOutput({tag, " busy after"}, 128'(bus.busy), 128'(0));
        step();
        checkOutput({tag, " done pulse width"}, 128'(bus.done), 128'(0));
        checkOutput({tag, " done count"}, 128'(doneSeen - prevDone), 128'(v.expDone));
        checkOutput({tag, " err count"}, 128'(errSeen - prevErr), 128'(v.expErr));
        cKey   = v.expKey;
        cAddr  = v.expAddr;
        cLoc   = v.expLoc;
        cMode  = v.expMode;
        cValid = v.expValid;
    endtask

    // Model: a frame commits its fields only when the XOR of all received bits is zero.
    function automatic vec_t modelFrame(input vec_t v);
        vec_t r;
        r = v;
        if ((^buildFrame(v)) == 1'b0) begin
            r.expKey = v.key; r.expAddr = v.addr; r.expLoc = v.loc; r.expMode = v.mode;
            r.expValid = 1'b1; r.expDone = 1'b1; r.expErr = 1'b0;
        end else begin
            r.expKey = cKey; r.expAddr = cAddr; r.expLoc = cLoc; r.expMode = cMode;
            r.expValid = cValid; r.expDone = 1'b0; r.expErr = 1'b1;
        end
        return r;
    endfunction

    initial begin
        vec_t v;
        int prevDone;
        int prevErr;

        vecs[0] = '{key: 128'h000102030405060708090A0B0C0D0E0F, addr: 8'hA5, loc: 8'h3C, mode: 1'b1,
                    flip: 1'b0, gapMode: 0,
                    expKey: 128'h000102030405060708090A0B0C0D0E0F, expAddr: 8'hA5, expLoc: 8'h3C,
                    expMode: 1'b1, expValid: 1'b1, expDone: 1'b1, expErr: 1'b0};
        vecs[1] = vecs[0];
        vecs[1].gapMode = 1;
        vecs[2] = '{key: {128{1'b1}}, addr: 8'h00, loc: 8'h5A, mode: 1'b0,
                    flip: 1'b1, gapMode: 0,
                    expKey: 128'h000102030405060708090A0B0C0D0E0F, expAddr: 8'hA5, expLoc: 8'h3C,
                    expMode: 1'b1, expValid: 1'b1, expDone: 1'b0, expErr: 1'b1};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.bit_valid = 1'b0;
        bus.serial_in = 1'b0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #5;
        checkOutput("reset key", 128'(bus.key), 128'(0));
        checkOutput("reset cfg_valid", 128'(bus.cfg_valid), 128'(0));
        checkOutput("reset busy", 128'(bus.busy), 128'(0));
        checkOutput("reset done", 128'(bus.done), 128'(0));
        #6 n_rst = 1'b1;
        cKey = '0; cAddr = '0; cLoc = '0; cMode = 1'b0; cValid = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            frameCheck(vecs[i], $sformatf("vec%0d", i), -1, 1'b0);
        end

        // Abort after 50 bits: nothing commits, then a fresh frame fully replaces the key.
        prevDone = doneSeen;
        prevErr  = errSeen;
        applyStimulus(buildFrame(vecs[2]), 0, -1, 50);
        bus.abort = 1'b1;
        bus.bit_valid = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.bit_valid = 1'b0;
        checkOutput("abort busy", 128'(bus.busy), 128'(0));
        checkOutput("abort key held", 128'(bus.key), 128'(cKey));
        checkOutput("abort address held", 128'(bus.address), 128'(cAddr));
        step();
        checkOutput("abort done count", 128'(doneSeen - prevDone), 128'(0));
        checkOutput("abort err count", 128'(errSeen - prevErr), 128'(0));
        v = '{key: 128'hFEDCBA98765432100123456789ABCDEF, addr: 8'h11, loc: 8'h77, mode: 1'b0,
              flip: 1'b0, gapMode: 0,
              expKey: 128'hFEDCBA98765432100123456789ABCDEF, expAddr: 8'h11, expLoc: 8'h77,
              expMode: 1'b0, expValid: 1'b1, expDone: 1'b1, expErr: 1'b0};
        frameCheck(v, "after abort", -1, 1'b0);

        // start mid-frame is ignored; abort during CHECK does not stop the commit.
        v.key = 128'h0F0E0D0C0B0A09080706050403020100; v.addr = 8'h42; v.loc = 8'h99; v.mode = 1'b1;
        v.expKey = v.key; v.expAddr = 8'h42; v.expLoc = 8'h99; v.expMode = 1'b1;
        frameCheck(v, "mid start", 40, 1'b0);
        v.addr = 8'h43; v.expAddr = 8'h43;
        frameCheck(v, "abort in check", -1, 1'b1);

        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        checkOutput("start+abort idle busy", 128'(bus.busy), 128'(0));
        bus.start = 1'b0;
        bus.abort = 1'b0;
        step();
        checkOutput("start+abort idle busy later", 128'(bus.busy), 128'(0));

        // Reset in the middle of a frame wipes everything without a pulse.
        applyStimulus(buildFrame(vecs[0]), 0, -1, 100);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midreset key", 128'(bus.key), 128'(0));
        checkOutput("midreset address", 128'(bus.address), 128'(0));
        checkOutput("midreset location", 128'(bus.location), 128'(0));
        checkOutput("midreset mode", 128'(bus.mode), 128'(0));
        checkOutput("midreset cfg_valid", 128'(bus.cfg_valid), 128'(0));
        checkOutput("midreset busy", 128'(bus.busy), 128'(0));
        checkOutput("midreset done", 128'(bus.done), 128'(0));
        #2 n_rst = 1'b1;
        cKey = '0; cAddr = '0; cLoc = '0; cMode = 1'b0; cValid = 1'b0;
        step();
        frameCheck(vecs[0], "post reset", -1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            v.key     = {$urandom, $urandom, $urandom, $urandom};
            v.addr    = ADDR_W'($urandom);
            v.loc     = LOC_W'($urandom);
            v.mode    = 1'($urandom_range(0, 1));
            v.flip    = ($urandom_range(0, 3) == 0);
            v.gapMode = $urandom_range(0, 2);
            v = modelFrame(v);
            frameCheck(v, $sformatf("rand%0d", n), -1, 1'b0);
        end

        checkOutput("done/err exclusive", 128'(bothHigh), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
